// File: rtl/ahb_master_arbiter_if.sv
// Bundle of the per-master request/address/data lines and the muxed slave-side bus
// seen by the round-robin AHB-Lite master arbiter.
interface ahb_master_arbiter_if #(
   parameter int N_MASTERS = 3,
   parameter int MW        = 2
);
   logic                      hready;
   logic [N_MASTERS-1:0]      hbusreq;
   logic [N_MASTERS-1:0]      hlock;
   logic [2*N_MASTERS-1:0]    htrans_i;
   logic [32*N_MASTERS-1:0]   haddr_i;
   logic [N_MASTERS-1:0]      hwrite_i;
   logic [3*N_MASTERS-1:0]    hsize_i;
   logic [32*N_MASTERS-1:0]   hwdata_i;

   logic [N_MASTERS-1:0]      hgrant;
   logic [MW-1:0]             hmaster;
   logic [MW-1:0]             hmaster_data;
   logic [1:0]                htrans;
   logic [31:0]               haddr;
   logic                      hwrite;
   logic [2:0]                hsize;
   logic [31:0]               hwdata;

   // The arbiter sits on the slave side of this bundle: it consumes requests.
   modport slave (
      input  hready, hbusreq, hlock, htrans_i, haddr_i, hwrite_i, hsize_i, hwdata_i,
      output hgrant, hmaster, hmaster_data, htrans, haddr, hwrite, hsize, hwdata
   );

   modport master (
      output hready, hbusreq, hlock, htrans_i, haddr_i, hwrite_i, hsize_i, hwdata_i,
      input  hgrant, hmaster, hmaster_data, htrans, haddr, hwrite, hsize, hwdata
   );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB-Lite master arbiter: registered grant, address mux by address-phase
// owner, write-data mux by data-phase owner; ownership moves only on transfer boundaries.
module ahb_master_arbiter #(
   parameter int N_MASTERS  = 3,
   parameter int MW         = 2,
   parameter int DEF_MASTER = 0,
   parameter int MAX_HOLD   = 16
) (
   input  logic               hclk,
   input  logic               hreset,
   ahb_master_arbiter_if.slave bus
);
   localparam int              HW       = $clog2(MAX_HOLD);
   localparam logic [1:0]      TR_IDLE  = 2'b00;
   localparam logic [1:0]      TR_SEQ   = 2'b11;
   localparam logic [MW-1:0]   DEF_IDX  = MW'(DEF_MASTER);
   localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      ST_PARK   = 2'd0,
      ST_OWNED  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [MW-1:0]         r_owner;
   logic [MW-1:0]         w_owner_next;
   logic [MW-1:0]         r_owner_data;
   logic [MW-1:0]         w_owner_data_next;
   logic [N_MASTERS-1:0]  r_grant;
   logic [N_MASTERS-1:0]  w_grant_next;
   logic [HW-1:0]         r_hold_cnt;
   logic [HW-1:0]         w_hold_next;
   logic [MW-1:0]         r_rr_ptr;
   logic [MW-1:0]         w_rr_next;

   logic [1:0]            w_trans [N_MASTERS];
   logic [31:0]           w_addr  [N_MASTERS];
   logic                  w_write [N_MASTERS];
   logic [2:0]            w_size  [N_MASTERS];
   logic [31:0]           w_wdata [N_MASTERS];

   generate
      for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
         assign w_trans[gi] = bus.htrans_i[2*gi +: 2];
         assign w_addr[gi]  = bus.haddr_i[32*gi +: 32];
         assign w_write[gi] = bus.hwrite_i[gi];
         assign w_size[gi]  = bus.hsize_i[3*gi +: 3];
         assign w_wdata[gi] = bus.hwdata_i[32*gi +: 32];
      end
   endgenerate

   // Returns {found, index} of the first requester strictly after base, base itself last.
   function automatic logic [MW:0] f_pick(input logic [MW-1:0] base,
                                          input logic [N_MASTERS-1:0] req);
      logic [MW:0]   res;
      logic [MW:0]   sum;
      logic [MW-1:0] idx;
      res = '0;
      for (int off = N_MASTERS; off >= 1; off--) begin
         sum = {1'b0, base} + (MW+1)'(off);
         if (sum >= (MW+1)'(N_MASTERS)) begin
            sum = sum - (MW+1)'(N_MASTERS);
         end
         idx = sum[MW-1:0];
         if (req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   logic [1:0]            w_owner_trans;
   logic                  w_boundary;
   logic                  w_owner_req;
   logic                  w_owner_lock;
   logic [N_MASTERS-1:0]  w_owner_mask;
   logic                  w_others_req;
   logic                  w_hold_sat;
   logic                  w_stay_locked;
   logic                  w_rearb;
   logic [MW:0]           w_pick_park;
   logic [MW:0]           w_pick_owned;

   assign w_owner_trans = w_trans[r_owner];
   assign w_boundary    = bus.hready && (w_owner_trans != TR_SEQ);
   assign w_owner_req   = bus.hbusreq[r_owner];
   assign w_owner_lock  = bus.hlock[r_owner];
   assign w_owner_mask  = N_MASTERS'(1) << r_owner;
   assign w_others_req  = |(bus.hbusreq & ~w_owner_mask);
   assign w_hold_sat    = (r_hold_cnt >= HOLD_MAX);
   assign w_pick_park   = f_pick(r_rr_ptr, bus.hbusreq);
   assign w_pick_owned  = f_pick(r_owner, bus.hbusreq);

   // A locked owner keeps the bus until it drops hlock on a boundary; that same edge
   // then falls through to the normal owned-state rules.
   assign w_stay_locked = (r_state == ST_LOCKED) && !(w_boundary && !w_owner_lock);
   assign w_rearb       = w_boundary && (!w_owner_req || (w_hold_sat && w_others_req));

   always_comb begin
      w_state_next      = r_state;
      w_owner_next      = r_owner;
      w_owner_data_next = r_owner_data;
      w_hold_next       = r_hold_cnt;
      w_rr_next         = r_rr_ptr;
      if (bus.hready) begin
         w_owner_data_next = r_owner;
         case (r_state)
            ST_PARK: begin
               w_hold_next = '0;
               if (w_pick_park[MW]) begin
                  w_owner_next = w_pick_park[MW-1:0];
                  w_state_next = bus.hlock[w_pick_park[MW-1:0]] ? ST_LOCKED : ST_OWNED;
               end else begin
                  w_owner_next = DEF_IDX;
               end
            end
            ST_OWNED, ST_LOCKED: begin
               if (!w_stay_locked) begin
                  if (w_boundary && w_owner_lock) begin
                     w_state_next = ST_LOCKED;
                  end else begin
                     w_state_next = ST_OWNED;
                     if (w_rearb) begin
                        w_hold_next = '0;
                        if (w_pick_owned[MW]) begin
                           w_owner_next = w_pick_owned[MW-1:0];
                        end else begin
                           w_owner_next = DEF_IDX;
                           w_state_next = ST_PARK;
                        end
                     end else if (!w_hold_sat) begin
                        w_hold_next = r_hold_cnt + 1'b1;
                     end
                  end
               end
            end
            default: begin
               w_state_next = ST_PARK;
               w_owner_next = DEF_IDX;
               w_hold_next  = '0;
            end
         endcase
      end
      if (w_owner_next != r_owner) begin
         w_rr_next = w_owner_next;
      end
   end

   assign w_grant_next = N_MASTERS'(1) << w_owner_next;

   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state      <= ST_PARK;
         r_owner      <= DEF_IDX;
         r_owner_data <= DEF_IDX;
         r_grant      <= N_MASTERS'(1) << DEF_IDX;
         r_hold_cnt   <= '0;
         r_rr_ptr     <= DEF_IDX;
      end else begin
         r_state      <= w_state_next;
         r_owner      <= w_owner_next;
         r_owner_data <= w_owner_data_next;
         r_grant      <= w_grant_next;
         r_hold_cnt   <= w_hold_next;
         r_rr_ptr     <= w_rr_next;
      end
   end

   logic w_park_idle;
   assign w_park_idle = (r_state == ST_PARK) && !w_owner_req;

   assign bus.hgrant       = r_grant;
   assign bus.hmaster      = r_owner;
   assign bus.hmaster_data = r_owner_data;
   assign bus.htrans       = w_park_idle ? TR_IDLE : w_owner_trans;
   assign bus.haddr        = w_addr[r_owner];
   assign bus.hwrite       = w_write[r_owner];
   assign bus.hsize        = w_size[r_owner];
   assign bus.hwdata       = w_wdata[r_owner_data];

   a_grant_onehot: assert property (@(posedge hclk) disable iff (hreset)
      $onehot(bus.hgrant));
   a_owner_range: assert property (@(posedge hclk) disable iff (hreset)
      (int'(bus.hmaster) < N_MASTERS));
   a_stall_freeze: assert property (@(posedge hclk) disable iff (hreset)
      !bus.hready |=> ($stable(bus.hgrant) && $stable(bus.hmaster_data)));
endmodule
